// File: rtl/dino_game_ctrl.sv
// -----------------------------------------------------------------------------
// dino_game_ctrl
//
// Game-flow controller for the dino runner. It sequences IDLE -> RUN -> OVER,
// keeps the running score, forwards jump requests to the jump unit, paces
// obstacle spawns with a pseudo-random interval and detects game-ending
// collisions.
//
// Parameters
//   SPAWN_BASE : minimum number of cycles between obstacle spawns
//   CLEAR_H    : dino_y at or above this height clears an obstacle
//   OVER_HOLD  : cycles spent in OVER before a restart is accepted
//   SCORE_MAX  : score saturation value
//
// Ports
//   clk_16Hz  in   game tick clock (the only clock)
//   rst       in   synchronous active-high reset
//   start_btn in   start/restart button, level, already debounced
//   up_btn    in   jump button, level
//   collide   in   obstacle overlaps the dino column this cycle
//   dino_y    in   [6:0] current dino height from the jump unit
//   freeze    out  freeze for the jump unit and the scroller
//   up_req    out  jump request forwarded to the jump unit
//   spawn     out  one-cycle obstacle spawn pulse
//   score     out  [13:0] current score, binary
//   state     out  [1:0] game state: IDLE=0, RUN=1, OVER=2
//   hi_score  out  [13:0] best score so far (only with DINO_HIGH_SCORE_EN)
//
// Build option
//   DINO_HIGH_SCORE_EN : when defined, adds the hi_score output and its
//                        register. Left undefined, the block has no
//                        high-score logic at all.
//
// All outputs come straight from flops.
// -----------------------------------------------------------------------------
module dino_game_ctrl #(
    parameter int SPAWN_BASE = 24,
    parameter int CLEAR_H    = 12,
    parameter int OVER_HOLD  = 16,
    parameter int SCORE_MAX  = 9999
) (
    input  logic        clk_16Hz,
    input  logic        rst,
    input  logic        start_btn,
    input  logic        up_btn,
    input  logic        collide,
    input  logic [6:0]  dino_y,
    output logic        freeze,
    output logic        up_req,
    output logic        spawn,
    output logic [13:0] score,
    output logic [1:0]  state
`ifdef DINO_HIGH_SCORE_EN
    ,
    output logic [13:0] hi_score
`endif
);

    // -------------------------------------------------------------------------
    // Constants sized to the signals they are compared against
    // -------------------------------------------------------------------------
    localparam int          DWELL_W      = $clog2(OVER_HOLD + 1);
    localparam logic [6:0]  CLEAR_H_V    = 7'(CLEAR_H);
    localparam logic [13:0] SCORE_MAX_V  = 14'(SCORE_MAX);
    localparam logic [5:0]  SPAWN_BASE_V = 6'(SPAWN_BASE);
    localparam logic [DWELL_W-1:0] OVER_HOLD_V = DWELL_W'(OVER_HOLD);
    localparam logic [7:0]  LFSR_SEED    = 8'hA5;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_OVER = 2'd2
    } state_t;

    // -------------------------------------------------------------------------
    // State and output registers
    // -------------------------------------------------------------------------
    state_t               state_q,       state_d;
    logic                 freeze_q,      freeze_d;
    logic                 up_req_q,      up_req_d;
    logic                 spawn_q,       spawn_d;
    logic [13:0]          score_q,       score_d;
    logic                 start_prev_q,  start_prev_d;
    logic [DWELL_W-1:0]   dwell_q,       dwell_d;
    logic [5:0]           spawn_cnt_q,   spawn_cnt_d;
    logic [7:0]           lfsr_q,        lfsr_d;
`ifdef DINO_HIGH_SCORE_EN
    logic [13:0]          hi_score_q,    hi_score_d;
`endif

    // -------------------------------------------------------------------------
    // Helper terms
    // -------------------------------------------------------------------------
    logic       start_rise;
    logic       hit;
    logic       lfsr_fb;
    logic [5:0] spawn_load;
    logic [13:0] score_inc;

    // Fibonacci LFSR, taps 8,6,5,4 (bits 7,5,4,3). The polynomial is
    // maximal-length, so from a nonzero seed it never reaches zero; the
    // zero check is a guard against upset state only.
    always_comb begin
        lfsr_fb = lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3];
        lfsr_d  = {lfsr_q[6:0], lfsr_fb};
        if (lfsr_d == 8'h00) begin
            lfsr_d = LFSR_SEED;
        end
    end

    always_comb begin
        start_rise = start_btn & ~start_prev_q;
        // Only low obstacles are dangerous; a high enough dino clears them.
        hit        = collide && (dino_y < CLEAR_H_V);
        // Interval is SPAWN_BASE plus 0..15 cycles of jitter.
        spawn_load = SPAWN_BASE_V + {2'b00, lfsr_q[3:0]};
        score_inc  = (score_q >= SCORE_MAX_V) ? SCORE_MAX_V : (score_q + 14'd1);
    end

    // -------------------------------------------------------------------------
    // Next-state logic
    // -------------------------------------------------------------------------
    always_comb begin
        state_d      = state_q;
        freeze_d     = freeze_q;
        up_req_d     = 1'b0;
        spawn_d      = 1'b0;
        score_d      = score_q;
        start_prev_d = start_btn;
        dwell_d      = dwell_q;
        spawn_cnt_d  = spawn_cnt_q;
`ifdef DINO_HIGH_SCORE_EN
        hi_score_d   = hi_score_q;
`endif

        case (state_q)
            ST_IDLE: begin
                freeze_d = 1'b1;
                if (start_rise) begin
                    state_d     = ST_RUN;
                    freeze_d    = 1'b0;
                    score_d     = 14'd0;
                    spawn_cnt_d = spawn_load;
                end
            end

            ST_RUN: begin
                freeze_d = 1'b0;
                up_req_d = up_btn;
                if (hit) begin
                    // Collision beats a same-cycle spawn: no pulse, no
                    // reload, and the score stops where it is.
                    state_d  = ST_OVER;
                    freeze_d = 1'b1;
                    up_req_d = 1'b0;
                    dwell_d  = '0;
`ifdef DINO_HIGH_SCORE_EN
                    if (score_q > hi_score_q) begin
                        hi_score_d = score_q;
                    end
`endif
                end else begin
                    score_d = score_inc;
                    // The spawn pulse is registered, so it is raised on the
                    // edge where the count steps down to zero; the pulse
                    // therefore occupies the counter's zero cycle, and the
                    // reload happens on that same edge. A count already at
                    // zero (only possible after upset) also fires.
                    if (spawn_cnt_q <= 6'd1) begin
                        spawn_d     = 1'b1;
                        spawn_cnt_d = spawn_load;
                    end else begin
                        spawn_cnt_d = spawn_cnt_q - 6'd1;
                    end
                end
            end

            ST_OVER: begin
                freeze_d = 1'b1;
                if (dwell_q < OVER_HOLD_V) begin
                    // Still dwelling: restart presses are swallowed.
                    dwell_d = dwell_q + DWELL_W'(1);
                end else if (start_rise) begin
                    state_d     = ST_RUN;
                    freeze_d    = 1'b0;
                    score_d     = 14'd0;
                    spawn_cnt_d = spawn_load;
                    dwell_d     = '0;
                end
            end

            default: begin
                // Encoding 3 is never entered legally; recover to IDLE.
                state_d  = ST_IDLE;
                freeze_d = 1'b1;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // Registers (reset overrides every same-cycle event)
    // -------------------------------------------------------------------------
    always_ff @(posedge clk_16Hz) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            freeze_q     <= 1'b1;
            up_req_q     <= 1'b0;
            spawn_q      <= 1'b0;
            score_q      <= 14'd0;
            start_prev_q <= 1'b0;
            dwell_q      <= '0;
            spawn_cnt_q  <= 6'd0;
            lfsr_q       <= LFSR_SEED;
`ifdef DINO_HIGH_SCORE_EN
            hi_score_q   <= 14'd0;
`endif
        end else begin
            state_q      <= state_d;
            freeze_q     <= freeze_d;
            up_req_q     <= up_req_d;
            spawn_q      <= spawn_d;
            score_q      <= score_d;
            start_prev_q <= start_prev_d;
            dwell_q      <= dwell_d;
            spawn_cnt_q  <= spawn_cnt_d;
            lfsr_q       <= lfsr_d;
`ifdef DINO_HIGH_SCORE_EN
            hi_score_q   <= hi_score_d;
`endif
        end
    end

    // -------------------------------------------------------------------------
    // Outputs
    // -------------------------------------------------------------------------
    assign freeze = freeze_q;
    assign up_req = up_req_q;
    assign spawn  = spawn_q;
    assign score  = score_q;
    assign state  = state_q;
`ifdef DINO_HIGH_SCORE_EN
    assign hi_score = hi_score_q;
`endif

endmodule

// File: tb/tb_dino_game_ctrl.sv
// -----------------------------------------------------------------------------
// tb_dino_game_ctrl
//
// Directed bench for dino_game_ctrl: a table of one-cycle vectors for the
// basic game flow, followed by hand-written sequences for spawn timing,
// reset priority, collision-vs-spawn, score saturation and (when built with
// DINO_HIGH_SCORE_EN) the high-score register.
// -----------------------------------------------------------------------------
module tb_dino_game_ctrl;

    logic        clk_16Hz = 1'b0;
    logic        rst = 1'b1;
    logic        start_btn = 1'b0;
    logic        up_btn = 1'b0;
    logic        collide = 1'b0;
    logic [6:0]  dino_y = 7'd0;
    logic        freeze;
    logic        up_req;
    logic        spawn;
    logic [13:0] score;
    logic [1:0]  state;
`ifdef DINO_HIGH_SCORE_EN
    logic [13:0] hi_score;
`endif

    int total = 0;
    int bad   = 0;

    dino_game_ctrl dut (
        .clk_16Hz  (clk_16Hz),
        .rst       (rst),
        .start_btn (start_btn),
        .up_btn    (up_btn),
        .collide   (collide),
        .dino_y    (dino_y),
        .freeze    (freeze),
        .up_req    (up_req),
        .spawn     (spawn),
        .score     (score),
        .state     (state)
`ifdef DINO_HIGH_SCORE_EN
        ,
        .hi_score  (hi_score)
`endif
    );

    always #5 clk_16Hz = ~clk_16Hz;

    typedef struct {
        logic        start;
        logic        up;
        logic        col;
        logic [6:0]  y;
        logic [1:0]  st;
        logic        fz;
        logic        ur;
        logic        sp;
        logic [13:0] sc;
    } vec_t;

    vec_t vq[$];

    task automatic add(input logic s, input logic u, input logic c, input logic [6:0] y,
                       input logic [1:0] st, input logic fz, input logic ur,
                       input logic sp, input logic [13:0] sc);
        vec_t v;
        v.start = s; v.up = u; v.col = c; v.y = y;
        v.st = st; v.fz = fz; v.ur = ur; v.sp = sp; v.sc = sc;
        vq.push_back(v);
    endtask

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s got=%0d exp=%0d", name, act, exp);
        end
    endtask

    // Advance one clock; outputs are then sampled 1 time unit after the edge.
    task automatic step();
        @(posedge clk_16Hz);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1; start_btn = 1'b0; up_btn = 1'b0; collide = 1'b0; dino_y = 7'd0;
        step();
        rst = 1'b0;
    endtask

    task automatic run_steps(input int n);
        for (int k = 0; k < n; k++) step();
    endtask

    initial begin
        int pulses;

        // ---------------- reset state ----------------
        do_reset();
        chk("rst_state",  state,  0);
        chk("rst_freeze", freeze, 1);
        chk("rst_upreq",  up_req, 0);
        chk("rst_spawn",  spawn,  0);
        chk("rst_score",  score,  0);

        // ---------------- table of vectors ----------------
        //   start up col y      st fz ur sp score
        add(0, 1, 1, 7'd0,  0, 1, 0, 0, 0);   // IDLE: jump and collide ignored
        add(1, 0, 0, 7'd0,  1, 0, 0, 0, 0);   // start edge -> RUN, score 0
        add(1, 0, 0, 7'd0,  1, 0, 0, 0, 1);   // held start, no edge
        add(0, 1, 0, 7'd0,  1, 0, 1, 0, 2);   // jump forwarded one cycle later
        add(0, 0, 0, 7'd0,  1, 0, 0, 0, 3);
        add(0, 0, 1, 7'd20, 1, 0, 0, 0, 4);   // high dino clears obstacle
        add(1, 0, 0, 7'd0,  1, 0, 0, 0, 5);   // start edge ignored in RUN
        add(0, 0, 1, 7'd4,  2, 1, 0, 0, 5);   // low dino hit -> OVER, score frozen
        for (int i = 8; i <= 24; i++) begin
            // Presses at dwell 10 (i=18) and dwell 15 (i=23) must be ignored;
            // i=9 also checks jump/collide are ignored in OVER.
            add((i == 18 || i == 23), (i == 9), (i == 9), 7'd0, 2, 1, 0, 0, 5);
        end
        add(1, 0, 0, 7'd0,  1, 0, 0, 0, 0);   // dwell complete -> RUN, score 0
        add(0, 0, 1, 7'd12, 1, 0, 0, 0, 1);   // dino_y == CLEAR_H clears
        add(0, 0, 1, 7'd11, 2, 1, 0, 0, 1);   // dino_y == CLEAR_H-1 hits

        for (int i = 0; i < vq.size(); i++) begin
            start_btn = vq[i].start; up_btn = vq[i].up;
            collide = vq[i].col; dino_y = vq[i].y;
            step();
            chk($sformatf("vec%0d_state",  i), state,  vq[i].st);
            chk($sformatf("vec%0d_freeze", i), freeze, vq[i].fz);
            chk($sformatf("vec%0d_upreq",  i), up_req, vq[i].ur);
            chk($sformatf("vec%0d_spawn",  i), spawn,  vq[i].sp);
            chk($sformatf("vec%0d_score",  i), score,  vq[i].sc);
            $display("vec %0d: st=%0d fz=%0d ur=%0d sp=%0d score=%0d", i, state, freeze, up_req, spawn, score);
        end
        start_btn = 0; up_btn = 0; collide = 0;

        // ---------------- first spawn timing ----------------
        do_reset();
        start_btn = 1'b1; step(); start_btn = 1'b0;
        chk("spawn_entry_state", state, 1);
        pulses = 0;
        for (int k = 1; k <= 35; k++) begin
            step();
            if (spawn) pulses++;
            if (k == 28) chk("spawn_k28", spawn, 0);
            if (k == 29) chk("spawn_k29", spawn, 1);
            if (k == 30) chk("spawn_k30", spawn, 0);
        end
        chk("spawn_pulse_count", pulses, 1);
        $display("seq spawn: pulses=%0d", pulses);

        // ---------------- reset beats a due spawn ----------------
        do_reset();
        start_btn = 1'b1; step(); start_btn = 1'b0;
        run_steps(28);
        rst = 1'b1; collide = 1'b1; dino_y = 7'd0;
        step();
        rst = 1'b0; collide = 1'b0;
        chk("rstrun_state",  state,  0);
        chk("rstrun_spawn",  spawn,  0);
        chk("rstrun_score",  score,  0);
        chk("rstrun_freeze", freeze, 1);
        $display("seq reset-in-run: st=%0d sp=%0d score=%0d", state, spawn, score);

        // ---------------- collision beats a due spawn ----------------
        do_reset();
        start_btn = 1'b1; step(); start_btn = 1'b0;
        run_steps(28);
        collide = 1'b1; dino_y = 7'd0;
        step();
        collide = 1'b0;
        chk("colspawn_state", state, 2);
        chk("colspawn_spawn", spawn, 0);
        chk("colspawn_score", score, 28);
        step();
        chk("colspawn_spawn_after", spawn, 0);
        $display("seq col+spawn: st=%0d sp=%0d score=%0d", state, spawn, score);
        rst = 1'b1; step(); rst = 1'b0;
        chk("rstover_state",  state,  0);
        chk("rstover_score",  score,  0);
        chk("rstover_freeze", freeze, 1);

        // ---------------- score saturation ----------------
        do_reset();
        start_btn = 1'b1; step(); start_btn = 1'b0;
        run_steps(9998);
        chk("sat_9998", score, 9998);
        step();
        chk("sat_9999", score, 9999);
        run_steps(4);
        chk("sat_hold", score, 9999);
        chk("sat_state", state, 1);
        $display("seq saturate: score=%0d", score);

`ifdef DINO_HIGH_SCORE_EN
        // ---------------- high score ----------------
        do_reset();
        chk("hi_rst", hi_score, 0);
        start_btn = 1'b1; step(); start_btn = 1'b0;
        run_steps(40);
        collide = 1'b1; step(); collide = 1'b0;
        chk("hi_g1_score", score, 40);
        chk("hi_g1", hi_score, 40);
        run_steps(16);
        start_btn = 1'b1; step(); start_btn = 1'b0;
        chk("hi_restart", state, 1);
        run_steps(25);
        collide = 1'b1; step(); collide = 1'b0;
        chk("hi_g2_score", score, 25);
        chk("hi_g2", hi_score, 40);
        rst = 1'b1; step(); rst = 1'b0;
        chk("hi_after_rst", hi_score, 0);
        $display("seq hi-score: hi=%0d", hi_score);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/dino_game_ctrl.md
DINO_GAME_CTRL -- requirements
Module: dino_game_ctrl

Interface
REQ-001 Parameter SPAWN_BASE, default 24: minimum cycles between obstacle spawns.
REQ-002 Parameter CLEAR_H, default 12: dino_y at or above this value clears an obstacle.
REQ-003 Parameter OVER_HOLD, default 16: cycles in OVER before a restart is accepted.
REQ-004 Parameter SCORE_MAX, default 9999: score saturation value.
REQ-005 clk_16Hz  in  1  game tick clock; the only clock.
REQ-006 rst  in  1  reset; synchronous, active-high.
REQ-007 start_btn  in  1  start/restart button, level; already debounced.
REQ-008 up_btn  in  1  jump button, level.
REQ-009 collide  in  1  obstacle overlaps the dino column this cycle.
REQ-010 dino_y  in  7  current dino height from the jump unit.
REQ-011 freeze  out  1  freeze for the jump unit and the scroller.
REQ-012 up_req  out  1  jump request forwarded to the jump unit.
REQ-013 spawn  out  1  one-cycle obstacle spawn pulse.
REQ-014 score  out  14  current score, binary.
REQ-015 state  out  2  game state: IDLE=0, RUN=1, OVER=2.

Function
REQ-016 Every output shall be registered; start_btn shall be edge-detected through an internal previous-value register that updates every cycle.
REQ-017 IDLE: freeze=1, up_req=0, spawn=0, score holds; a rising edge of start_btn shall enter RUN on the next cycle, with score=0, freeze=0 and the spawn counter loaded.
REQ-018 RUN: score shall increment by 1 each cycle and saturate at SCORE_MAX; up_req shall equal up_btn, registered with one cycle of latency.
REQ-019 Spawn counter: 6-bit, loaded with SPAWN_BASE + lfsr[3:0], decremented each RUN cycle; at 0 it shall assert spawn for one cycle and reload.
REQ-020 LFSR: 8-bit Fibonacci, taps 8,6,5,4, seed 8'hA5, advancing every cycle in every state; it shall never hold 0.
REQ-021 Collision: in RUN, collide=1 with dino_y < CLEAR_H shall enter OVER on the next cycle; collide with dino_y >= CLEAR_H shall be ignored.
REQ-022 When a collision and a spawn-counter zero fall in the same cycle, the collision shall win: spawn=0 and the counter shall not reload.
REQ-023 OVER: freeze=1, up_req=0, spawn=0, score frozen; a dwell counter shall count OVER_HOLD cycles.
REQ-024 A start_btn rising edge during the dwell shall be ignored; a rising edge after the dwell shall enter RUN exactly as REQ-017 specifies.
REQ-025 collide shall be ignored in IDLE and OVER; start_btn edges shall be ignored in RUN.
REQ-026 Encoding 3 shall be unreachable; if it occurs, the block shall go to IDLE on the next cycle.

Reset
REQ-027 rst=1 at a clock edge shall force: state=IDLE, freeze=1, up_req=0, spawn=0, score=0, start-edge register=0, dwell=0, spawn counter=0, LFSR=8'hA5.
REQ-028 Reset asserted mid-RUN or mid-OVER shall abort immediately with no spawn pulse; rst shall take priority over every event in the same cycle.

Configuration
REQ-029 Macro DINO_HIGH_SCORE_EN: when defined, the block shall add the output hi_score (14 bits, reset 0), updated to score on each RUN->OVER transition when score > hi_score, and held through restarts.
REQ-030 When DINO_HIGH_SCORE_EN is undefined, hi_score and its register shall not exist, and all other behaviour shall be unchanged.

Verification
REQ-031 Reset, then hold start_btn=1 for one cycle -> next cycle state=1, freeze=0, score=0; score=5 after 5 further cycles.
REQ-032 RUN with up_btn=1 at cycle N -> up_req=1 at N+1; up_btn=1 in IDLE -> up_req stays 0.
REQ-033 First load after reset: LFSR 8'hA5 so lfsr[3:0]=5 -> first spawn pulse 29 cycles after entering RUN, one cycle wide.
REQ-034 collide=1 with dino_y=20 -> stays RUN; collide=1 with dino_y=4 -> state=2 next cycle; score frozen; start at dwell cycle 10 ignored; start after cycle 16 -> RUN with score=0.
REQ-035 Force score to 9998, run 5 cycles -> score=9999 and holds; collision in the same cycle as a spawn-counter zero -> spawn=0, state=2.
REQ-036 With DINO_HIGH_SCORE_EN: game 1 ends at score 40, game 2 at 25 -> hi_score=40; rst -> hi_score=0.
